// File: rtl/lw_hmac_digest_out.sv
// lw_hmac_digest_out: captures the core digest on a done edge and streams it out word by word; HMAC_VERIFY_EN adds a constant-time tag compare
module lw_hmac_digest_out #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 8
) (
  input  logic                            clk_i,
  input  logic                            aresetn_i,
  input  logic                            done_i,
  input  logic [N_WORDS-1:0][WORD_W-1:0]  hash_i,
  input  logic [3:0]                      len_i,
  input  logic                            abort_i,
`ifdef HMAC_VERIFY_EN
  input  logic                            verify_i,
  input  logic [N_WORDS-1:0][WORD_W-1:0]  exp_i,
  output logic                            match_o,
  output logic                            match_valid_o,
`endif
  output logic [WORD_W-1:0]               out_data_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            out_last_o,
  output logic                            busy_o,
  output logic                            overrun_o
);
  localparam int IW = $clog2(N_WORDS);
  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef HMAC_VERIFY_EN
    , CMP
`endif
  } state_t;
  state_t state, state_d, cap_state;
  logic done_q, cap, adv;
  logic [N_WORDS-1:0][WORD_W-1:0] dig;
  logic [IW-1:0] idx;
  logic [3:0] rem, n;
  assign cap = done_i & ~done_q;
  assign n = (len_i == 4'd0 || len_i > 4'(N_WORDS)) ? 4'(N_WORDS) : len_i;
  // a stream advances on a beat, a compare advances every cycle
  assign adv = busy_o & (out_ready_i | ~out_valid_o);
`ifdef HMAC_VERIFY_EN
  assign cap_state = verify_i ? CMP : SEND;
`else
  assign cap_state = SEND;
`endif
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      dig       <= '0;
      idx       <= '0;
      rem       <= '0;
      overrun_o <= 1'b0;
    end else begin
      state  <= state_d;
      done_q <= done_i;
      if (abort_i) begin
        dig <= '0;
      end else if (state == IDLE && cap) begin
        dig       <= hash_i;
        idx       <= IW'(N_WORDS - 1);
        rem       <= n;
        overrun_o <= 1'b0;
      end else begin
        if (cap) overrun_o <= 1'b1;
        if (adv) begin
          idx <= idx - 1'b1;
          rem <= rem - 1'b1;
        end
      end
    end
  end
  always_comb begin
    state_d = state;
    if (abort_i) state_d = IDLE;
    else if (state == IDLE) state_d = cap ? cap_state : IDLE;
    else if (adv && rem == 4'd1) state_d = IDLE;
  end
  always_comb begin
    out_valid_o = state == SEND;
    out_data_o  = out_valid_o ? dig[idx] : '0;
    out_last_o  = out_valid_o && rem == 4'd1;
    busy_o      = state != IDLE;
  end
`ifdef HMAC_VERIFY_EN
  logic diff, diff_now;
  // every word is folded in regardless of earlier mismatches
  assign diff_now = diff | (|(dig[idx] ^ exp_i[idx]));
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      diff          <= 1'b0;
      match_o       <= 1'b0;
      match_valid_o <= 1'b0;
    end else begin
      match_valid_o <= 1'b0;
      if (abort_i) begin
        if (state == CMP) match_o <= 1'b0;
      end else if (state == IDLE && cap) begin
        diff    <= 1'b0;
        match_o <= 1'b0;
      end else if (state == CMP) begin
        diff <= diff_now;
        if (rem == 4'd1) begin
          match_o       <= ~diff_now;
          match_valid_o <= 1'b1;
        end
      end
    end
  end
`endif
endmodule
